// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- combinational 16-op ALU with a registered status (flag) register.
//
// Ports
//   CLK    in   rising-edge clock, used only by the status register
//   RST_N  in   asynchronous active-low reset (clears SR only)
//   ABUS   in   [WIDTH-1:0] operand A
//   BBUS   in   [WIDTH-1:0] operand B
//   FSEL   in   [3:0] operation select
//   CIN    in   carry-in, consumed only by RLC / RRC
//   FLGEN  in   status-register load enable
//   FOUT   out  [WIDTH-1:0] result (combinational)
//   Z,S,C,V out zero / sign / carry-borrow / overflow flags (combinational)
//   SR     out  [3:0] registered flags {V,C,S,Z}
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] ABUS,
  input  logic [WIDTH-1:0] BBUS,
  input  logic [3:0]       FSEL,
  input  logic             CIN,
  input  logic             FLGEN,
  output logic [WIDTH-1:0] FOUT,
  output logic             Z,
  output logic             S,
  output logic             C,
  output logic             V,
  output logic [3:0]       SR
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_TSA = 4'h0;
  localparam logic [3:0] OP_INC = 4'h1;
  localparam logic [3:0] OP_DEC = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;
  localparam logic [3:0] OP_RLC = 4'hC;
  localparam logic [3:0] OP_RRC = 4'hD;

  localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

  // One extra bit on every adder: the top bit is the carry (add) or the
  // borrow (subtract, two's-complement wraparound sets it when A < B).
  logic [WIDTH:0] add_w, sub_w, inc_w, dec_w;
  logic [WIDTH-1:0] res;
  logic c_flag, v_flag;
  logic [3:0] sr_q, sr_d;

  assign add_w = {1'b0, ABUS} + {1'b0, BBUS};
  assign sub_w = {1'b0, ABUS} - {1'b0, BBUS};
  assign inc_w = {1'b0, ABUS} + ONE_W;
  assign dec_w = {1'b0, ABUS} - ONE_W;

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (FSEL)
      OP_TSA: res = ABUS;
      OP_INC: begin
        res    = inc_w[MSB:0];
        c_flag = inc_w[WIDTH];
        v_flag = ~ABUS[MSB] & inc_w[MSB];
      end
      OP_DEC: begin
        res    = dec_w[MSB:0];
        c_flag = dec_w[WIDTH];
        v_flag = ABUS[MSB] & ~dec_w[MSB];
      end
      OP_ADD: begin
        res    = add_w[MSB:0];
        c_flag = add_w[WIDTH];
        v_flag = (ABUS[MSB] == BBUS[MSB]) & (add_w[MSB] != ABUS[MSB]);
      end
      OP_SUB: begin
        res    = sub_w[MSB:0];
        c_flag = sub_w[WIDTH];
        v_flag = (ABUS[MSB] != BBUS[MSB]) & (sub_w[MSB] != ABUS[MSB]);
      end
      OP_AND: res = ABUS & BBUS;
      OP_OR:  res = ABUS | BBUS;
      OP_XOR: res = ABUS ^ BBUS;
      OP_NOT: res = ~ABUS;
      OP_SHL: begin
        res    = {ABUS[MSB-1:0], 1'b0};
        c_flag = ABUS[MSB];
        v_flag = ABUS[MSB] ^ ABUS[MSB-1];
      end
      OP_SHR: begin
        res    = {1'b0, ABUS[MSB:1]};
        c_flag = ABUS[0];
        v_flag = ABUS[MSB];
      end
      OP_ASR: begin
        res    = {ABUS[MSB], ABUS[MSB:1]};
        c_flag = ABUS[0];
      end
      OP_RLC: begin
        res    = {ABUS[MSB-1:0], CIN};
        c_flag = ABUS[MSB];
        v_flag = ABUS[MSB] ^ ABUS[MSB-1];
      end
      OP_RRC: begin
        res    = {CIN, ABUS[MSB:1]};
        c_flag = ABUS[0];
        v_flag = CIN ^ ABUS[MSB];
      end
      default: ; // reserved codes: zero result, Z=1 via the zero detect below
    endcase
  end

  assign FOUT = res;
  assign Z    = ~|res;
  assign S    = res[MSB];
  assign C    = c_flag;
  assign V    = v_flag;

  assign sr_d = FLGEN ? {v_flag, c_flag, res[MSB], ~|res} : sr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sr_q <= 4'b0000;
    else        sr_q <= sr_d;
  end

  assign SR = sr_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        CLK, RST_N, CIN, FLGEN;
  logic [15:0] ABUS, BBUS, FOUT;
  logic [3:0]  FSEL, SR;
  logic        Z, S, C, V;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Directed vector: op, A, B, CIN, expected result, expected {Z,S,C,V}.
  typedef struct {
    logic [3:0]  f;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] r;
    logic [3:0]  zscv;
  } dv_t;

  logic [19:0] sb[$];

  alu #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .ABUS(ABUS), .BBUS(BBUS), .FSEL(FSEL),
    .CIN(CIN), .FLGEN(FLGEN), .FOUT(FOUT), .Z(Z), .S(S), .C(C), .V(V),
    .SR(SR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model built from integer arithmetic ranges rather than sign bits.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f, input logic cin);
    int ua, ub, sa, sb_i, t;
    logic [15:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = $signed(a); sb_i = $signed(b);
    r = 16'h0; c = 1'b0; v = 1'b0;
    case (f)
      4'h0: r = a;
      4'h1: begin t = ua + 1; r = t[15:0]; c = (t > 65535); v = (sa + 1 > 32767); end
      4'h2: begin t = ua - 1; r = t[15:0]; c = (t < 0); v = (sa - 1 < -32768); end
      4'h3: begin t = ua + ub; r = t[15:0]; c = (t > 65535);
                  v = (sa + sb_i > 32767) || (sa + sb_i < -32768); end
      4'h4: begin t = ua - ub; r = t[15:0]; c = (ua < ub);
                  v = (sa - sb_i > 32767) || (sa - sb_i < -32768); end
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: r = ~a;
      4'h9: begin t = (ua * 2) % 65536; r = t[15:0]; c = a[15];
                  v = (sa * 2 > 32767) || (sa * 2 < -32768); end
      4'hA: begin t = ua / 2; r = t[15:0]; c = a[0]; v = a[15]; end
      4'hB: begin t = (sa >>> 1); r = t[15:0]; c = a[0]; end
      4'hC: begin t = (ua * 2 + int'(cin)) % 65536; r = t[15:0]; c = a[15];
                  v = (sa * 2 > 32767) || (sa * 2 < -32768); end
      4'hD: begin t = ua / 2 + (cin ? 32768 : 0); r = t[15:0]; c = a[0];
                  v = cin ^ a[15]; end
      default: r = 16'h0;
    endcase
    return {r, (r == 16'h0), r[15], c, v};
  endfunction

  task automatic test_reset();
    logic [19:0] got, want;
    RST_N = 1'b0; FLGEN = 1'b1; CIN = 1'b0;
    ABUS = 16'h7FFF; BBUS = 16'h0001; FSEL = 4'h3;
    #1;
    vec_cnt++;
    if (SR !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_sr_async: got %b want 0000", SR);
    end
    repeat (2) @(posedge CLK);
    #1;
    vec_cnt++;
    if (SR !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_sr_hold_with_flgen: got %b want 0000", SR);
    end
    // Combinational path must stay alive during reset.
    sb.push_back({16'h8000, 4'b0101});
    #1;
    got = {FOUT, Z, S, C, V}; want = sb.pop_front();
    vec_cnt++;
    if (got !== want) begin
      err_cnt++; $display("FAIL reset_comb_add: got %h want %h", got, want);
    end
  endtask

  task automatic test_arith();
    dv_t t[13];
    logic [19:0] got, want;
    t = '{
      '{4'h3, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 4'b0011},
      '{4'h3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101},
      '{4'h3, 16'hFFFB, 16'h0006, 1'b0, 16'h0001, 4'b0010},
      '{4'h3, 16'h0001, 16'h0001, 1'b1, 16'h0002, 4'b0000},
      '{4'h4, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b0111},
      '{4'h4, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0001},
      '{4'h4, 16'hFFFC, 16'h0005, 1'b0, 16'hFFF7, 4'b0100},
      '{4'h4, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b1000},
      '{4'h1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b1010},
      '{4'h1, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 4'b0101},
      '{4'h2, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b0110},
      '{4'h2, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 4'b0001},
      '{4'h0, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 4'b0000}
    };
    foreach (t[i]) begin
      ABUS = t[i].a; BBUS = t[i].b; FSEL = t[i].f; CIN = t[i].cin;
      sb.push_back({t[i].r, t[i].zscv});
      #1;
      got = {FOUT, Z, S, C, V}; want = sb.pop_front();
      vec_cnt++;
      if (got !== want) begin
        err_cnt++;
        $display("FAIL arith[%0d] f=%h a=%h b=%h: got %h want %h",
                 i, t[i].f, t[i].a, t[i].b, got, want);
      end
    end
  endtask

  task automatic test_logic_shift();
    dv_t t[12];
    logic [19:0] got, want;
    t = '{
      '{4'h5, 16'hAAAA, 16'h5555, 1'b0, 16'h0000, 4'b1000},
      '{4'h6, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 4'b0000},
      '{4'h7, 16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 4'b0100},
      '{4'h8, 16'hAAAA, 16'h1234, 1'b0, 16'h5555, 4'b0000},
      '{4'h9, 16'h8001, 16'h0000, 1'b0, 16'h0002, 4'b0011},
      '{4'hA, 16'h8001, 16'h0000, 1'b0, 16'h4000, 4'b0011},
      '{4'hB, 16'h8001, 16'h0000, 1'b0, 16'hC000, 4'b0110},
      '{4'hC, 16'h8001, 16'h0000, 1'b1, 16'h0003, 4'b0011},
      '{4'hD, 16'h0001, 16'h0000, 1'b1, 16'h8000, 4'b0111},
      '{4'hD, 16'h8001, 16'h0000, 1'b1, 16'hC000, 4'b0110},
      '{4'hE, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b1000},
      '{4'hF, 16'h8001, 16'h7FFF, 1'b1, 16'h0000, 4'b1000}
    };
    foreach (t[i]) begin
      ABUS = t[i].a; BBUS = t[i].b; FSEL = t[i].f; CIN = t[i].cin;
      sb.push_back({t[i].r, t[i].zscv});
      #1;
      got = {FOUT, Z, S, C, V}; want = sb.pop_front();
      vec_cnt++;
      if (got !== want) begin
        err_cnt++;
        $display("FAIL logic_shift[%0d] f=%h a=%h cin=%b: got %h want %h",
                 i, t[i].f, t[i].a, t[i].cin, got, want);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] got, want;
    for (int i = 0; i < 300; i++) begin
      ABUS = 16'($urandom); BBUS = 16'($urandom);
      FSEL = 4'($urandom_range(15)); CIN = 1'($urandom);
      if (i % 5 == 0) ABUS = (i % 2 == 0) ? 16'hFFFF : 16'h8000;
      sb.push_back(model(ABUS, BBUS, FSEL, CIN));
      #1;
      got = {FOUT, Z, S, C, V}; want = sb.pop_front();
      vec_cnt++;
      if (got !== want) begin
        err_cnt++;
        $display("FAIL random[%0d] f=%h a=%h b=%h cin=%b: got %h want %h",
                 i, FSEL, ABUS, BBUS, CIN, got, want);
      end
    end
  endtask

  task automatic test_status_reg();
    FLGEN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    ABUS = 16'h0000; BBUS = 16'h0000; FSEL = 4'h2; CIN = 1'b0; FLGEN = 1'b1;
    @(posedge CLK); #1;
    vec_cnt++;
    if (SR !== 4'b0110) begin
      err_cnt++; $display("FAIL sr_first_load_dec0: got %b want 0110", SR);
    end
    @(negedge CLK);
    FLGEN = 1'b0; ABUS = 16'h8000; BBUS = 16'hFFFF; FSEL = 4'h3;
    @(posedge CLK); #1;
    vec_cnt++;
    if (SR !== 4'b0110) begin
      err_cnt++; $display("FAIL sr_hold: got %b want 0110", SR);
    end
    @(negedge CLK);
    FLGEN = 1'b1;
    @(posedge CLK); #1;
    vec_cnt++;
    if (SR !== 4'b1100) begin
      err_cnt++; $display("FAIL sr_reload_add: got %b want 1100", SR);
    end
    #1 RST_N = 1'b0;
    #1;
    vec_cnt++;
    if (SR !== 4'b0000) begin
      err_cnt++; $display("FAIL sr_async_midcycle: got %b want 0000", SR);
    end
    @(posedge CLK); #1;
    vec_cnt++;
    if (SR !== 4'b0000) begin
      err_cnt++; $display("FAIL sr_reset_beats_load: got %b want 0000", SR);
    end
    @(negedge CLK);
    RST_N = 1'b1; FLGEN = 1'b0;
  endtask

  initial begin
    test_reset();
    FLGEN = 1'b0;
    test_arith();
    test_logic_shift();
    test_random();
    test_status_reg();
    if (sb.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
